level_shift_modulator: RTL and testbench

Consumer of the carrier generator's outputs: it compares a double-buffered signed reference against the two level-shifted carriers and produces the eight gate signals for the two cascaded H-bridges of the 5-level inverter. Each leg gets complementary drive with programmable dead time. The reference is updated only on `sync_pulse`. When only one bridge is active, the active bridge alternates every carrier period to balance stress between the bridges.

---
 rtl/level_shift_modulator.sv | 167 ++++++++++++++++
 tb/tb_level_shift_modulator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/level_shift_modulator.sv
`default_nettype none
// ============================================================================
// Module   : level_shift_modulator
// Purpose  : Level-shifted PWM for a 5-level cascaded H-bridge inverter, with
//            bridge rotation and per-leg dead-time insertion.
// Revision : 1.0 - initial release
// ============================================================================
module level_shift_modulator #(
  parameter int DATA_WIDTH = 16,
  parameter int DT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] ref_in,
  input  logic                  ref_valid,
  input  logic [DATA_WIDTH-1:0] carrier1,
  input  logic [DATA_WIDTH-1:0] carrier2,
  input  logic                  sync_pulse,
  input  logic [DT_WIDTH-1:0]   deadtime,
  output logic [7:0]            gate,
  output logic [2:0]            level_out
);

  localparam logic [DATA_WIDTH-1:0] c_MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] c_MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH:0]   c_THR_BASE = {2'b00, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_DEAD  = 2'd0,
    ST_ON_HI = 2'd1,
    ST_ON_LO = 2'd2
  } leg_state_t;

  logic [DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0] r_ref_act;
  logic                  r_rot;
  logic [2:0]            r_level;

  logic [DATA_WIDTH-1:0] w_mag;
  logic [DATA_WIDTH:0]   w_a2;
  logic [DATA_WIDTH:0]   w_thr_hi;
  logic [DATA_WIDTH:0]   w_c2;
  logic [1:0]            w_m;
  logic [2:0]            w_level;
  logic [DT_WIDTH-1:0]   w_dt;
  logic                  w_l_one;
  logic                  w_l_two;
  logic                  w_h1_act;
  logic                  w_h2_act;
  logic [3:0]            w_cmd;

  // A same-cycle strobe and sync bypasses the shadow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_ref_act <= '0;
    end else begin
      if (ref_valid)  r_shadow  <= ref_in;
      if (sync_pulse) r_ref_act <= ref_valid ? ref_in : r_shadow;
    end
  end

  always_comb begin
    w_mag = r_ref_act;
    if (r_ref_act[DATA_WIDTH-1]) begin
      if (r_ref_act == c_MOST_NEG) w_mag = c_MAX_POS;
      else                         w_mag = -r_ref_act;
    end
  end

  assign w_a2     = {w_mag, 1'b0};
  assign w_thr_hi = c_THR_BASE - {carrier1[DATA_WIDTH-1], carrier1};
  assign w_c2     = {1'b0, carrier2};
  assign w_m      = {1'b0, (w_a2 > w_c2)} + {1'b0, (w_a2 > w_thr_hi)};
  assign w_level  = r_ref_act[DATA_WIDTH-1] ? -{1'b0, w_m} : {1'b0, w_m};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rot   <= 1'b0;
      r_level <= '0;
    end else begin
      if (enable && sync_pulse) r_rot <= ~r_rot;
      r_level <= enable ? w_level : 3'd0;
    end
  end

  assign level_out = r_level;

  assign w_l_one  = (r_level == 3'b001) || (r_level == 3'b111);
  assign w_l_two  = (r_level == 3'b010) || (r_level == 3'b110);
  assign w_h1_act = w_l_two || (w_l_one && !r_rot);
  assign w_h2_act = w_l_two || (w_l_one &&  r_rot);

  // Leg order: H1A, H1B, H2A, H2B; command 1 selects the high switch.
  assign w_cmd[0] = w_h1_act && !r_level[2];
  assign w_cmd[1] = w_h1_act &&  r_level[2];
  assign w_cmd[2] = w_h2_act && !r_level[2];
  assign w_cmd[3] = w_h2_act &&  r_level[2];

  assign w_dt = (deadtime == '0) ? DT_WIDTH'(1) : deadtime;

  for (genvar i = 0; i < 4; i++) begin : g_leg
    leg_state_t          r_state;
    leg_state_t          w_state_nxt;
    logic [DT_WIDTH-1:0] r_cnt;
    logic [DT_WIDTH-1:0] w_cnt_nxt;
    logic                r_tgt;
    logic                w_tgt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_DEAD;
        r_cnt   <= '0;
        r_tgt   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_tgt   <= w_tgt_nxt;
      end
    end

    // A zero count after reset forces a full dead time before first turn-on.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tgt_nxt   = r_tgt;
      if (!enable) begin
        w_state_nxt = ST_DEAD;
        w_cnt_nxt   = w_dt;
        w_tgt_nxt   = w_cmd[i];
      end else begin
        case (r_state)
          ST_ON_HI: begin
            if (!w_cmd[i]) begin
              w_state_nxt = ST_DEAD;
              w_cnt_nxt   = w_dt;
              w_tgt_nxt   = 1'b0;
            end
          end
          ST_ON_LO: begin
            if (w_cmd[i]) begin
              w_state_nxt = ST_DEAD;
              w_cnt_nxt   = w_dt;
              w_tgt_nxt   = 1'b1;
            end
          end
          default: begin
            if ((w_cmd[i] != r_tgt) || (r_cnt == '0)) begin
              w_cnt_nxt = w_dt;
              w_tgt_nxt = w_cmd[i];
            end else if (r_cnt == DT_WIDTH'(1)) begin
              w_state_nxt = w_cmd[i] ? ST_ON_HI : ST_ON_LO;
            end else begin
              w_cnt_nxt = r_cnt - DT_WIDTH'(1);
            end
          end
        endcase
      end
    end

    assign gate[2*i]   = (r_state == ST_ON_HI);
    assign gate[2*i+1] = (r_state == ST_ON_LO);
  end

endmodule
`default_nettype wire

// File: tb/tb_level_shift_modulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_level_shift_modulator
// Purpose  : Directed self-checking bench for level_shift_modulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_level_shift_modulator;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        enable     = 1'b1;
  logic [15:0] ref_in     = '0;
  logic        ref_valid  = 1'b0;
  logic [15:0] carrier1   = '0;
  logic [15:0] carrier2   = '0;
  logic        sync_pulse = 1'b0;
  logic [7:0]  deadtime   = 8'd3;
  logic [7:0]  gate;
  logic [2:0]  level_out;

  int total = 0;
  int bad   = 0;

  level_shift_modulator #(
    .DATA_WIDTH (16),
    .DT_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .ref_in     (ref_in),
    .ref_valid  (ref_valid),
    .carrier1   (carrier1),
    .carrier2   (carrier2),
    .sync_pulse (sync_pulse),
    .deadtime   (deadtime),
    .gate       (gate),
    .level_out  (level_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_ref(input logic [15:0] v);
    ref_in    = v;
    ref_valid = 1'b1;
    tick();
    ref_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
  endtask

  // Hi and lo of any leg must never be on together.
  always @(negedge clk) begin
    if (rst_n) check("hi_lo_excl", gate & (gate >> 1) & 8'h55, 8'h00);
  end

  initial begin
    // Reset held with enable high and busy inputs
    for (int i = 0; i < 4; i++) begin
      carrier1   = (i % 2 == 0) ? 16'hB1E0 : 16'hFF9C;
      carrier2   = (i % 2 == 0) ? 16'd10000 : 16'd30000;
      ref_in     = 16'd32767;
      ref_valid  = 1'b1;
      sync_pulse = 1'b1;
      tick();
      check("rst_gate", gate, 8'h00);
      check("rst_level", {5'b0, level_out}, 8'h00);
    end
    ref_valid  = 1'b0;
    sync_pulse = 1'b0;
    carrier1   = 16'hB1E0;  // -20000
    carrier2   = 16'd10000;
    deadtime   = 8'd3;
    rst_n      = 1'b1;
    tick(5);

    // L=+1, rotation lands on H2
    load_ref(16'd16384);
    pulse_sync();
    tick(20);
    check("l1_level", {5'b0, level_out}, 8'h01);
    check("l1_rot1_gate", gate, 8'h9A);

    // Rotate to H1 with a 3-cycle dead band on the changing legs
    pulse_sync();
    check("rot_edge", gate, 8'h9A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rot_dead3", gate, 8'h88);
    end
    tick();
    check("rot0_gate", gate, 8'hA9);

    // Dead time 5: H1A hi falls, H1A lo rises 5 cycles later
    deadtime = 8'd5;
    pulse_sync();
    check("dt5_edge", gate, 8'hA9);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dt5_band", gate, 8'h88);
    end
    tick();
    check("dt5_on", gate, 8'h9A);

    // Reversal one cycle into the dead band restarts the full dead time
    sync_pulse = 1'b1;
    tick();
    check("rev_edge", gate, 8'h9A);
    tick();
    sync_pulse = 1'b0;
    check("rev_drop", gate, 8'h88);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rev_band", gate, 8'h88);
    end
    tick();
    check("rev_return", gate, 8'h9A);

    // Full positive level
    load_ref(16'd32767);
    pulse_sync();
    tick(20);
    check("p2_level", {5'b0, level_out}, 8'h02);
    check("p2_gate", gate, 8'h99);

    // Same-cycle strobe and sync at the negative extreme
    ref_in     = 16'h8000;
    ref_valid  = 1'b1;
    sync_pulse = 1'b1;
    tick();
    ref_valid  = 1'b0;
    sync_pulse = 1'b0;
    tick();
    check("same_cycle_level", {5'b0, level_out}, 8'h06);
    tick(20);
    check("n2_level", {5'b0, level_out}, 8'h06);
    check("n2_gate", gate, 8'h66);

    // Enable dropped inside a dead band
    ref_in     = 16'd16384;
    ref_valid  = 1'b1;
    sync_pulse = 1'b1;
    tick();
    ref_valid  = 1'b0;
    sync_pulse = 1'b0;
    check("en_pre_edge", gate, 8'h66);
    tick();
    check("en_pre_level", {5'b0, level_out}, 8'h01);
    tick();
    check("en_pre_band", gate, 8'h20);
    enable = 1'b0;
    tick();
    check("dis_gate", gate, 8'h00);
    check("dis_level", {5'b0, level_out}, 8'h00);
    tick(2);
    check("dis_hold", gate, 8'h00);

    // Re-enable waits a full dead time before any turn-on
    enable = 1'b1;
    tick();
    check("reen_level", {5'b0, level_out}, 8'h01);
    check("reen_gate", gate, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reen_wait", gate, 8'h00);
    end
    tick();
    check("reen_lo_on", gate, 8'hA8);
    tick(2);
    check("reen_final", gate, 8'hA9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
